// File: rtl/cache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_arbiter_pkg
// Shared types and helpers for the I/D-cache miss arbiter.
//   arb_state_t       : arbiter FSM states
//   arb_grant_t       : which requester owns (or last owned) the memory port
//   line_offset_bits(): byte-offset bits within one cache line
// -----------------------------------------------------------------------------
package cache_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Offset bits for the default 256-bit line.
  localparam int LINE_OFS_BITS = 5;

  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage : cache_arbiter_pkg

// File: rtl/cache_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational round-robin pick between the I-side and D-side requesters.
//   i_req      in   I-side request pending
//   d_req      in   D-side request pending (read or write)
//   last_grant in   side granted most recently
//   valid      out  at least one request pending
//   pick       out  side to grant; on conflict, the side not granted last
// -----------------------------------------------------------------------------
module arb_rr_pick
  import cache_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output logic       valid,
  output arb_grant_t pick
);

  always_comb begin
    valid = i_req | d_req;
    // D wins when it is alone, or when both ask and I had the port last.
    if (d_req && (!i_req || last_grant == GRANT_I)) begin
      pick = GRANT_D;
    end else begin
      pick = GRANT_I;
    end
  end

endmodule : arb_rr_pick

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Shares one line-wide memory port between I-cache fills and D-cache
// fills/writebacks. One requester is granted at a time; its line-aligned
// address, operation and write data are latched on the grant edge, the memory
// port is driven until mem_resp, the returned line is buffered, and a
// one-cycle resp pulse hands it back. Conflicts alternate round-robin.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_address        I-cache fill request (held until i_resp)
//   i_rdata, i_resp          I-side returned line and completion pulse
//   d_read, d_write          D-cache fill / writeback request (held until d_resp)
//   d_address, d_wdata       D-side address and writeback line
//   d_rdata, d_resp          D-side returned line and completion pulse
//   mem_read, mem_write      memory strobes
//   mem_address, mem_wdata   line-aligned address and write line to memory
//   mem_rdata, mem_resp      line from memory and its one-cycle completion
// -----------------------------------------------------------------------------
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter bit D_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int OFS = line_offset_bits(LINE_WIDTH);

  arb_state_t            state, state_next;
  arb_grant_t            last_grant;
  arb_grant_t            pick;
  logic                  req_valid;
  logic                  grant;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] req_addr;

  arb_rr_pick u_rr_pick (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .valid      (req_valid),
    .pick       (pick)
  );

  assign grant    = (state == IDLE) && req_valid;
  assign req_addr = (pick == GRANT_D) ? d_address : i_address;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_next = (pick == GRANT_D) ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        // Strobes come from the latched operation, never the live request.
        mem_read = 1'b1;
        if (mem_resp) state_next = DONE_I;
      end
      SERVE_D: begin
        mem_read  = !op_write;
        mem_write = op_write;
        if (mem_resp) state_next = DONE_D;
      end
      DONE_I: begin
        i_resp     = 1'b1;
        state_next = IDLE;
      end
      DONE_D: begin
        d_resp     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= D_FIRST ? GRANT_I : GRANT_D;
      op_write    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant  <= pick;
        mem_address <= {req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
        // Write wins when d_read and d_write are raised together.
        op_write    <= (pick == GRANT_D) && d_write;
        if (pick == GRANT_D) mem_wdata <= d_wdata;
      end
      // The per-side rdata registers are the line buffers; writes leave them alone.
      if (mem_resp && !op_write) begin
        if (state == SERVE_I) i_rdata <= mem_rdata;
        if (state == SERVE_D) d_rdata <= mem_rdata;
      end
    end
  end

  a_d_read_write_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(d_read && d_write)
  );

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
// Directed bench for cache_arbiter. A small memory model answers strobes after
// a programmable number of cycles; each scenario task drives requests and
// compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  // Memory model controls.
  logic          mem_en;
  int            mem_lat;
  logic          use_pattern;
  logic [LW-1:0] pattern;
  logic          model_resp;
  logic          man_resp;
  int            mem_cnt;

  int n_checks;
  int n_fail;

  assign mem_resp = model_resp | man_resp;

  cache_arbiter #(
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW),
    .D_FIRST    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers on the mem_lat-th cycle a strobe is seen; read data is
  // either a fixed pattern or the line address replicated across the line.
  always @(negedge clk) begin
    if (!mem_en) begin
      mem_cnt    = 0;
      model_resp = 1'b0;
    end else if (mem_read || mem_write) begin
      mem_cnt    = mem_cnt + 1;
      model_resp = (mem_cnt == mem_lat);
      mem_rdata  = use_pattern ? pattern : {8{mem_address}};
    end else begin
      mem_cnt    = 0;
      model_resp = 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    n_checks++;
    if (mem_address !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_address, mem_wdata);
    end
    n_checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i %h d %h expected 0", i_rdata, d_rdata);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: cycle %0d got %b expected 0000", c,
                 {mem_read, mem_write, i_resp, d_resp});
      end
    end
  endtask

  task automatic test_i_read();
    int rd_cycles = 0;
    int resp_at   = -1;
    mem_lat     = 3;
    use_pattern = 1'b1;
    pattern     = {32{8'hA5}};
    @(negedge clk);
    i_address = 32'h0000_0064;
    i_read    = 1'b1;
    for (int c = 1; c <= 20 && resp_at < 0; c++) begin
      @(negedge clk);
      if (mem_read) begin
        rd_cycles++;
        n_checks++;
        if (mem_address !== 32'h0000_0060) begin
          n_fail++;
          $display("FAIL i_read_addr: got %h expected 00000060", mem_address);
        end
      end
      if (mem_write || d_resp) begin
        n_checks++;
        n_fail++;
        $display("FAIL i_read_stray: got mem_write %b d_resp %b expected 0 0", mem_write, d_resp);
      end
      if (i_resp) begin
        resp_at = c;
        i_read  = 1'b0;
        n_checks++;
        if (i_rdata !== {32{8'hA5}}) begin
          n_fail++;
          $display("FAIL i_read_data: got %h expected a5..a5", i_rdata);
        end
      end
    end
    n_checks++;
    if (resp_at != 4) begin
      n_fail++;
      $display("FAIL i_read_latency: got resp at cycle %0d expected 4", resp_at);
    end
    n_checks++;
    if (rd_cycles != 3) begin
      n_fail++;
      $display("FAIL i_read_strobe_len: got %0d expected 3", rd_cycles);
    end
    @(negedge clk);
    n_checks++;
    if (i_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL i_resp_pulse: got %b one cycle later expected 0", i_resp);
    end
  endtask

  task automatic test_d_write();
    int wr_cycles = 0;
    int resp_at   = -1;
    mem_lat     = 2;
    use_pattern = 1'b0;
    @(negedge clk);
    d_address = 32'h1000_0020;
    d_wdata   = {8{32'h1111_1111}};
    d_write   = 1'b1;
    for (int c = 1; c <= 20 && resp_at < 0; c++) begin
      @(negedge clk);
      if (mem_write) begin
        wr_cycles++;
        n_checks++;
        if (mem_address !== 32'h1000_0020 || mem_wdata !== {8{32'h1111_1111}}) begin
          n_fail++;
          $display("FAIL d_write_bus: got addr %h wdata %h expected 10000020 11..11",
                   mem_address, mem_wdata);
        end
      end
      if (mem_read || i_resp) begin
        n_checks++;
        n_fail++;
        $display("FAIL d_write_stray: got mem_read %b i_resp %b expected 0 0", mem_read, i_resp);
      end
      if (d_resp) begin
        resp_at = c;
        d_write = 1'b0;
        n_checks++;
        if (d_rdata !== '0) begin
          n_fail++;
          $display("FAIL d_write_rdata: got %h expected 0 (unchanged)", d_rdata);
        end
        n_checks++;
        if (i_rdata !== {32{8'hA5}}) begin
          n_fail++;
          $display("FAIL d_write_other_side: got i_rdata %h expected a5..a5", i_rdata);
        end
      end
    end
    n_checks++;
    if (resp_at != 3 || wr_cycles != 2) begin
      n_fail++;
      $display("FAIL d_write_timing: got resp %0d strobes %0d expected 3 2", resp_at, wr_cycles);
    end
    @(negedge clk);
    n_checks++;
    if (d_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL d_resp_pulse: got %b one cycle later expected 0", d_resp);
    end
  endtask

  // Both sides request continuously (drop for one cycle after each resp, then
  // re-raise); grants must alternate D, I, D, I ... starting with D.
  task automatic test_conflict();
    int   done   = 0;
    int   issued = 2;
    logic i_pend = 1'b0;
    logic d_pend = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    mem_lat     = 1;
    use_pattern = 1'b0;
    i_address   = 32'h0000_2044;
    d_address   = 32'h0000_3088;
    i_read      = 1'b1;
    d_read      = 1'b1;
    for (int c = 0; c < 200 && done < 8; c++) begin
      @(negedge clk);
      if (i_pend) begin i_read = 1'b1; i_pend = 1'b0; end
      if (d_pend) begin d_read = 1'b1; d_pend = 1'b0; end
      if (i_resp && d_resp) begin
        n_checks++;
        n_fail++;
        $display("FAIL conflict_both_resp: got i_resp and d_resp high together");
      end else if (i_resp || d_resp) begin
        n_checks++;
        if (d_resp !== ((done % 2) == 0)) begin
          n_fail++;
          $display("FAIL conflict_order: grant %0d got d_side %b expected %b",
                   done, d_resp, ((done % 2) == 0));
        end
        n_checks++;
        if (d_resp && d_rdata !== {8{32'h0000_3080}}) begin
          n_fail++;
          $display("FAIL conflict_d_data: got %h expected 00003080 x8", d_rdata);
        end else if (i_resp && i_rdata !== {8{32'h0000_2040}}) begin
          n_fail++;
          $display("FAIL conflict_i_data: got %h expected 00002040 x8", i_rdata);
        end
        if (d_resp) begin d_read = 1'b0; d_pend = (issued < 8); end
        else        begin i_read = 1'b0; i_pend = (issued < 8); end
        if (issued < 8) issued++;
        done++;
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    n_checks++;
    if (done != 8) begin
      n_fail++;
      $display("FAIL conflict_rounds: got %0d completions expected 8", done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_serve();
    int strobes = 0;
    int resp_at = -1;
    mem_lat   = 5;
    d_address = 32'h0000_5000;
    d_read    = 1'b1;
    for (int c = 0; c < 10 && strobes < 2; c++) begin
      @(negedge clk);
      if (mem_read) strobes++;
    end
    #2 rst = 1'b1;
    d_read = 1'b0;
    #1;
    n_checks++;
    if (strobes != 2 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_strobes: got strobes_seen %0d rd %b wr %b expected 2 0 0",
               strobes, mem_read, mem_write);
    end
    @(negedge clk);
    rst    = 1'b0;
    mem_en = 1'b0;
    @(negedge clk);
    man_resp = 1'b1;
    @(negedge clk);
    man_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
        n_fail++;
        $display("FAIL stray_mem_resp: cycle %0d got %b expected 0000", c,
                 {mem_read, mem_write, i_resp, d_resp});
      end
    end
    n_checks++;
    if (d_rdata !== '0) begin
      n_fail++;
      $display("FAIL abort_rdata: got %h expected 0", d_rdata);
    end
    mem_en  = 1'b1;
    mem_lat = 2;
    d_read  = 1'b1;
    for (int c = 1; c <= 20 && resp_at < 0; c++) begin
      @(negedge clk);
      if (d_resp) begin
        resp_at = c;
        d_read  = 1'b0;
        n_checks++;
        if (d_rdata !== {8{32'h0000_5000}}) begin
          n_fail++;
          $display("FAIL after_abort_data: got %h expected 00005000 x8", d_rdata);
        end
      end
    end
    n_checks++;
    if (resp_at != 3) begin
      n_fail++;
      $display("FAIL after_abort_latency: got %0d expected 3", resp_at);
    end
  endtask

  // Address and operation change while SERVE_D is active must not leak out.
  task automatic test_input_change();
    int strobes = 0;
    int resp_at = -1;
    mem_lat   = 4;
    @(negedge clk);
    d_address = 32'h0000_4000;
    d_read    = 1'b1;
    for (int c = 1; c <= 20 && resp_at < 0; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        strobes++;
        n_checks++;
        if (mem_address !== 32'h0000_4000 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
          n_fail++;
          $display("FAIL latched_req: got addr %h rd %b wr %b expected 00004000 1 0",
                   mem_address, mem_read, mem_write);
        end
        if (strobes == 1) begin
          d_address = 32'hFFFF_FFE0;
          d_read    = 1'b0;
          d_write   = 1'b1;
        end
      end
      if (d_resp) begin
        resp_at = c;
        d_write = 1'b0;
        n_checks++;
        if (d_rdata !== {8{32'h0000_4000}}) begin
          n_fail++;
          $display("FAIL latched_data: got %h expected 00004000 x8", d_rdata);
        end
      end
    end
    n_checks++;
    if (strobes != 4 || resp_at != 5) begin
      n_fail++;
      $display("FAIL latched_timing: got strobes %0d resp %0d expected 4 5", strobes, resp_at);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    i_read      = 1'b0;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_address   = '0;
    d_wdata     = '0;
    mem_en      = 1'b1;
    mem_lat     = 1;
    use_pattern = 1'b0;
    pattern     = '0;
    man_resp    = 1'b0;
    model_resp  = 1'b0;
    mem_cnt     = 0;
    mem_rdata   = '0;
    test_reset();
    test_i_read();
    test_d_write();
    test_conflict();
    test_reset_mid_serve();
    test_input_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule : tb_cache_arbiter
